// File: rtl/sm4_pkg.sv
// Shared widths, FSM states and the buffered block-plus-key payload for the SM4 input packer.
package sm4_pkg;

    localparam int unsigned SM4_WORD_W = 32;
    localparam int unsigned SM4_BLK_W  = 128;
    localparam int unsigned SM4_DEPTH  = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DROP    = 2'd1,
        START   = 2'd2,
        BURST   = 2'd3
    } sm4_state_e;

    typedef struct packed {
        logic [SM4_BLK_W-1:0] data;
        logic [SM4_BLK_W-1:0] key;
    } sm4_blk_t;

endpackage

// File: rtl/sm4_in_pack_if.sv
// 32-bit word stream with valid/ready handshake and last-word flag.
interface sm4_in_pack_if;
    import sm4_pkg::*;

    logic [SM4_WORD_W-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/sm4_blk_buf.sv
// DEPTH x (block + key) register FIFO holding one message until it is replayed.
module sm4_blk_buf
    import sm4_pkg::*;
#(
    parameter int unsigned DEPTH = SM4_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  sm4_blk_t                     wr_blk,
    input  logic                         rd_en,
    output sm4_blk_t                     rd_blk_c,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    sm4_blk_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= wr_blk;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_blk_c = mem[rd_ptr];

endmodule

// File: rtl/sm4_in_pack.sv
// Packs a 32-bit word stream into 128-bit blocks, buffers a message and replays it as an SM4 burst.
// Define SM4_IN_PACK_ZPAD_EN to zero-pad a partial final block instead of rejecting the message.
module sm4_in_pack
    import sm4_pkg::*;
#(
    parameter int unsigned DEPTH = SM4_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    sm4_in_pack_if.slave         s_if,
    input  logic [SM4_BLK_W-1:0] key_in,
    input  logic                 key_we,
    input  logic                 err_clr,
    output logic [SM4_BLK_W-1:0] datain,
    output logic [SM4_BLK_W-1:0] mkin,
    output logic                 start_input,
    output logic                 end_input,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned ASM_W = 3 * SM4_WORD_W;

`ifdef SM4_IN_PACK_ZPAD_EN
    localparam bit ZPAD_EN = 1'b1;
`else
    localparam bit ZPAD_EN = 1'b0;
`endif

    sm4_state_e           state_q, state_d;
    logic [1:0]           wcnt_q, wcnt_d;
    logic [ASM_W-1:0]     asm_q, asm_d;
    logic [SM4_BLK_W-1:0] key_q;
    logic                 s_ready_q;

    logic                 s_ready_d, start_d, end_d, busy_d, err_set;
    logic [SM4_BLK_W-1:0] datain_d, mkin_d;

    logic                 accept_c, blk_done_c;
    logic [SM4_BLK_W-1:0] blk_data_c;
    sm4_blk_t             wr_blk_c, rd_blk_c;
    logic                 buf_wr, buf_rd, buf_flush;
    logic [CW-1:0]        buf_count;

    assign s_if.s_ready = s_ready_q;
    assign accept_c     = s_if.s_valid && s_ready_q;
    assign blk_done_c   = (wcnt_q == 2'd3) || s_if.s_last;

    // Left-align the held words plus the incoming word; missing low-order words read as zero.
    always_comb begin
        blk_data_c = '0;
        case (wcnt_q)
            2'd0:    blk_data_c = {s_if.s_data, (3*SM4_WORD_W)'(0)};
            2'd1:    blk_data_c = {asm_q[SM4_WORD_W-1:0], s_if.s_data, (2*SM4_WORD_W)'(0)};
            2'd2:    blk_data_c = {asm_q[2*SM4_WORD_W-1:0], s_if.s_data, SM4_WORD_W'(0)};
            default: blk_data_c = {asm_q, s_if.s_data};
        endcase
    end

    // A key write in the completing cycle is the key that travels with the block.
    assign wr_blk_c.data = blk_data_c;
    assign wr_blk_c.key  = key_we ? key_in : key_q;

    sm4_blk_buf #(.DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (buf_flush),
        .wr_en    (buf_wr),
        .wr_blk   (wr_blk_c),
        .rd_en    (buf_rd),
        .rd_blk_c (rd_blk_c),
        .count    (buf_count)
    );

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        asm_d     = asm_q;
        buf_wr    = 1'b0;
        buf_rd    = 1'b0;
        buf_flush = 1'b0;
        err_set   = 1'b0;
        end_d     = 1'b0;
        datain_d  = '0;
        mkin_d    = '0;

        case (state_q)
            COLLECT: begin
                if (accept_c) begin
                    asm_d = {asm_q[2*SM4_WORD_W-1:0], s_if.s_data};
                    if (blk_done_c) begin
                        wcnt_d = 2'd0;
                        if (s_if.s_last) begin
                            if ((wcnt_q == 2'd3) || ZPAD_EN) begin
                                buf_wr  = 1'b1;
                                state_d = START;
                            end else begin
                                err_set   = 1'b1;
                                buf_flush = 1'b1;
                            end
                        end else if (buf_count == CW'(DEPTH - 1)) begin
                            err_set   = 1'b1;
                            buf_flush = 1'b1;
                            state_d   = DROP;
                        end else begin
                            buf_wr = 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
            end
            DROP: begin
                buf_flush = 1'b1;
                wcnt_d    = 2'd0;
                if (accept_c && s_if.s_last) begin
                    state_d = COLLECT;
                end
            end
            START: begin
                datain_d = rd_blk_c.data;
                mkin_d   = rd_blk_c.key;
                buf_rd   = 1'b1;
                end_d    = (buf_count == CW'(1));
                state_d  = BURST;
            end
            BURST: begin
                if (buf_count != '0) begin
                    datain_d = rd_blk_c.data;
                    mkin_d   = rd_blk_c.key;
                    buf_rd   = 1'b1;
                    end_d    = (buf_count == CW'(1));
                end else begin
                    state_d = COLLECT;
                end
            end
        endcase

        s_ready_d = (state_d == COLLECT) || (state_d == DROP);
        start_d   = (state_d == START);
        busy_d    = (state_d == START) || (state_d == BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            wcnt_q      <= '0;
            asm_q       <= '0;
            key_q       <= '0;
            s_ready_q   <= 1'b1;
            datain      <= '0;
            mkin        <= '0;
            start_input <= 1'b0;
            end_input   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            asm_q       <= asm_d;
            if (key_we) begin
                key_q <= key_in;
            end
            s_ready_q   <= s_ready_d;
            datain      <= datain_d;
            mkin        <= mkin_d;
            start_input <= start_d;
            end_input   <= end_d;
            busy        <= busy_d;
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
